// File: rtl/stream_pkg.sv
// stream_pkg: shared source ids and FSM encoding for the stream arbiter
package stream_pkg;
    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;
    typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_e;
endpackage

// File: rtl/stream_arb_2x1_if.sv
// stream_arb_2x1_if: two valid/ready sources, select and one valid/ready output
interface stream_arb_2x1_if #(parameter int DATA_W = 8);
    logic              a_valid, a_ready, b_valid, b_ready, s, y_valid, y_ready;
    logic [DATA_W-1:0] a_data, b_data, y_data;
    modport slave (
        input  a_valid, a_data, b_valid, b_data, y_ready,
        output a_ready, b_ready, s, y_valid, y_data
    );
    modport master (
        output a_valid, a_data, b_valid, b_data, y_ready,
        input  a_ready, b_ready, s, y_valid, y_data
    );
endinterface

// File: rtl/rr_grant_2.sv
// rr_grant_2: combinational two-way round-robin grant
module rr_grant_2
    import stream_pkg::*;
(
    input  logic a_valid_i,
    input  logic b_valid_i,
    input  logic last_grant_i,
    output logic gnt_a_o,
    output logic gnt_b_o,
    output logic any_o
);
    assign gnt_a_o = a_valid_i & (~b_valid_i | (last_grant_i == SRC_B));
    assign gnt_b_o = b_valid_i & (~a_valid_i | (last_grant_i == SRC_A));
    assign any_o   = a_valid_i | b_valid_i;
endmodule

// File: rtl/stream_arb_2x1.sv
// stream_arb_2x1: round-robin 2:1 stream arbiter with a one-word registered output
module stream_arb_2x1
    import stream_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    stream_arb_2x1_if.slave   io
);
    state_e            state_q, state_d;
    logic              last_q, last_d, s_q, s_d;
    logic [DATA_W-1:0] y_data_q, y_data_d;
    logic              gnt_a, gnt_b, any, load, xfer;

    rr_grant_2 u_grant (
        .a_valid_i    (io.a_valid),
        .b_valid_i    (io.b_valid),
        .last_grant_i (last_q),
        .gnt_a_o      (gnt_a),
        .gnt_b_o      (gnt_b),
        .any_o        (any)
    );

    assign load = (state_q == ST_EMPTY) | io.y_ready;
    assign xfer = load & any;

    always_comb begin
        state_d  = xfer ? ST_FULL : (io.y_ready ? ST_EMPTY : state_q);
        s_d      = xfer ? (gnt_b ? SRC_B : SRC_A) : s_q;
        last_d   = xfer ? s_d : last_q;
        y_data_d = xfer ? (gnt_b ? io.b_data : io.a_data) : y_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_EMPTY;
            s_q      <= SRC_A;
            last_q   <= SRC_B;
            y_data_q <= '0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            last_q   <= last_d;
            y_data_q <= y_data_d;
        end
    end

    // readies are gated by rst_n so nothing is accepted while flops are held in reset
    assign io.a_ready = rst_n & load & gnt_a;
    assign io.b_ready = rst_n & load & gnt_b;
    assign io.y_valid = (state_q == ST_FULL);
    assign io.y_data  = y_data_q;
    assign io.s       = s_q;
endmodule
